// File: rtl/debug_writer.sv
//==============================================================================
// Module  : debug_writer
// Brief   : Byte-stream debug loader. Writes RF/DM from header/data byte pairs
//           and launches the CPU on END_CMD. Optional read-back verify is
//           enabled by defining DEBUG_WRITER_VERIFY_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module debug_writer #(
    parameter logic [7:0] END_CMD = 8'hFF,
    parameter int         CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             rf_we,
    output logic [1:0]       rf_addr,
    output logic             dm_we,
    output logic [3:0]       dm_addr,
    output logic [7:0]       wr_data,
    output logic             start,
    input  logic             stopped,
    output logic             dbg_is_dm,
    output logic [3:0]       dbg_addr,
    input  logic [7:0]       rd_data,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] write_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_WRITE  = 3'd2,
        S_VERIFY = 3'd3,
        S_LAUNCH = 3'd4,
        S_RUN    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_hdr_dm;
    logic [3:0]       r_hdr_addr;
    logic             r_rf_we;
    logic             r_dm_we;
    logic [1:0]       r_rf_addr;
    logic [3:0]       r_dm_addr;
    logic [7:0]       r_wr_data;
    logic             r_start;
    logic             r_run_first;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_in_ready;

`ifdef DEBUG_WRITER_VERIFY_EN
    logic             r_err;
    logic             r_dbg_is_dm;
    logic [3:0]       r_dbg_addr;
`else
    logic             w_unused_rd_data;
    assign w_unused_rd_data = ^rd_data;
`endif

    // Ready is masked while reset is held so nothing is handshaken during it.
    assign w_in_ready = ~reset & ((r_state == S_IDLE) | (r_state == S_DATA));
    assign w_accept   = in_valid & w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hdr_dm    <= 1'b0;
            r_hdr_addr  <= 4'd0;
            r_rf_we     <= 1'b0;
            r_dm_we     <= 1'b0;
            r_rf_addr   <= 2'd0;
            r_dm_addr   <= 4'd0;
            r_wr_data   <= 8'd0;
            r_start     <= 1'b0;
            r_run_first <= 1'b0;
            r_count     <= '0;
`ifdef DEBUG_WRITER_VERIFY_EN
            r_err       <= 1'b0;
            r_dbg_is_dm <= 1'b0;
            r_dbg_addr  <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_byte == END_CMD) begin
                            r_start <= 1'b1;
                            r_state <= S_LAUNCH;
                        end else begin
                            r_hdr_dm   <= in_byte[7];
                            r_hdr_addr <= in_byte[3:0];
                            r_state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // Strobe, address and data are registered together so they
                    // are all valid for the whole single WRITE cycle.
                    if (w_accept) begin
                        r_wr_data <= in_byte;
                        if (r_hdr_dm) begin
                            r_dm_we   <= 1'b1;
                            r_dm_addr <= r_hdr_addr;
                        end else begin
                            r_rf_we   <= 1'b1;
                            r_rf_addr <= r_hdr_addr[1:0];
                        end
                        if (r_count != c_cnt_max) begin
                            r_count <= r_count + 1'b1;
                        end
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_rf_we <= 1'b0;
                    r_dm_we <= 1'b0;
`ifdef DEBUG_WRITER_VERIFY_EN
                    r_dbg_is_dm <= r_hdr_dm;
                    r_dbg_addr  <= r_hdr_dm ? r_hdr_addr : {2'b00, r_hdr_addr[1:0]};
                    r_state     <= S_VERIFY;
`else
                    r_state <= S_IDLE;
`endif
                end
                S_VERIFY: begin
`ifdef DEBUG_WRITER_VERIFY_EN
                    if (rd_data != r_wr_data) begin
                        r_err <= 1'b1;
                    end
                    r_dbg_is_dm <= 1'b0;
                    r_dbg_addr  <= 4'd0;
`endif
                    r_state <= S_IDLE;
                end
                S_LAUNCH: begin
                    r_start     <= 1'b0;
                    r_run_first <= 1'b1;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    // The CPU may still report its old halted flag right after start.
                    if (r_run_first) begin
                        r_run_first <= 1'b0;
                    end else if (stopped) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign busy        = (r_state != S_IDLE);
    assign rf_we       = r_rf_we;
    assign dm_we       = r_dm_we;
    assign rf_addr     = r_rf_addr;
    assign dm_addr     = r_dm_addr;
    assign wr_data     = r_wr_data;
    assign start       = r_start;
    assign write_count = r_count;

`ifdef DEBUG_WRITER_VERIFY_EN
    assign err       = r_err;
    assign dbg_is_dm = r_dbg_is_dm;
    assign dbg_addr  = r_dbg_addr;
`else
    assign err       = 1'b0;
    assign dbg_is_dm = 1'b0;
    assign dbg_addr  = 4'd0;
`endif

endmodule

`default_nettype wire
